// File: rtl/gpio_ahb_master_pkg.sv
// gpio_ahb_master_pkg: shared AHB transfer encodings, phase states and the command record.
package gpio_ahb_pkg;
    localparam int BUS_W = 32;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    typedef enum logic {IDLE, ADDR} phase_t;
    typedef struct packed {
        logic             write;
        logic [BUS_W-1:0] addr;
        logic [BUS_W-1:0] wdata;
    } cmd_t;
endpackage

// File: rtl/gpio_ahb_master_if.sv
// gpio_ahb_master_if: AHB-Lite bus between the initiator and the GPIO subordinate.
interface gpio_ahb_master_if #(parameter int WIDTH = 16);
    logic [2*WIDTH-1:0] HADDR;
    logic [2*WIDTH-1:0] HWDATA;
    logic [2*WIDTH-1:0] HRDATA;
    logic [1:0]         HTRANS;
    logic               HWRITE;
    logic               HSEL;
    logic               HREADY;
    logic               HREADYOUT;
    modport master (output HADDR, HWDATA, HTRANS, HWRITE, HSEL, HREADY, input HREADYOUT, HRDATA);
    modport slave  (input HADDR, HWDATA, HTRANS, HWRITE, HSEL, HREADY, output HREADYOUT, HRDATA);
endinterface

// File: rtl/gpio_ahb_master.sv
// gpio_ahb_master: valid/ready commands to pipelined single-word AHB-Lite NONSEQ transfers.
// GPIO_AHB_MASTER_PARITY_EN adds PARITYSEL drive and PARITYERR reporting on rsp_err.
module gpio_ahb_master
    import gpio_ahb_pkg::*;
#(
    parameter int WIDTH = BUS_W / 2
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [2*WIDTH-1:0] cmd_addr,
    input  logic [2*WIDTH-1:0] cmd_wdata,
    output logic               rsp_valid,
    output logic               rsp_write,
    output logic [2*WIDTH-1:0] rsp_rdata,
    output logic               busy,
`ifdef GPIO_AHB_MASTER_PARITY_EN
    input  logic               cfg_parity_odd,
    output logic               PARITYSEL,
    input  logic               PARITYERR,
    output logic               rsp_err,
`endif
    gpio_ahb_master_if.master  ahb
);
    phase_t state_q, state_d;
    cmd_t   cmd_q;
    logic   data_q, dwrite_q, accept, done, advance;

    assign cmd_ready  = ahb.HREADYOUT && !HRESET;
    assign accept     = cmd_valid && cmd_ready;
    assign advance    = state_q == ADDR && ahb.HREADYOUT;
    assign done       = data_q && ahb.HREADYOUT;
    assign busy       = state_q == ADDR || data_q;
    assign ahb.HREADY = ahb.HREADYOUT;
    assign ahb.HTRANS = state_q == ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahb.HSEL   = state_q == ADDR;
    assign ahb.HADDR  = cmd_q.addr;
    assign ahb.HWRITE = cmd_q.write;

    always_comb begin
        state_d = state_q;
        state_d = accept ? ADDR : advance ? IDLE : state_q;
    end

    // Address and data slots share HREADYOUT, so a slot advancing always retires the prior data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            data_q     <= 1'b0;
            dwrite_q   <= 1'b0;
            ahb.HWDATA <= '0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= done;
            if (accept) cmd_q <= '{write: cmd_write, addr: {cmd_addr[2*WIDTH-1:2], 2'b00}, wdata: cmd_wdata};
            if (advance) begin
                data_q     <= 1'b1;
                dwrite_q   <= cmd_q.write;
                ahb.HWDATA <= cmd_q.wdata;
            end else if (ahb.HREADYOUT) begin
                data_q <= 1'b0;
            end
            if (done) begin
                rsp_write <= dwrite_q;
                rsp_rdata <= dwrite_q ? '0 : ahb.HRDATA;
            end
        end
    end

`ifdef GPIO_AHB_MASTER_PARITY_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            PARITYSEL <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) PARITYSEL <= cfg_parity_odd;
            rsp_err <= done && PARITYERR;
        end
    end
`endif
endmodule

// File: tb/tb_gpio_ahb_master.sv
// tb_gpio_ahb_master: directed scenarios for gpio_ahb_master with hand-computed expectations.
module tb_gpio_ahb_master;
    localparam int W = 16;
    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [2*W-1:0] cmd_addr, cmd_wdata, rsp_rdata;
    logic          rsp_valid, rsp_write, busy;
`ifdef GPIO_AHB_MASTER_PARITY_EN
    logic          cfg_parity_odd, PARITYSEL, PARITYERR, rsp_err;
`endif
    int checks = 0;
    int errors = 0;

    gpio_ahb_master_if #(.WIDTH(W)) ahb ();

    gpio_ahb_master #(.WIDTH(W)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .busy(busy),
`ifdef GPIO_AHB_MASTER_PARITY_EN
        .cfg_parity_odd(cfg_parity_odd), .PARITYSEL(PARITYSEL), .PARITYERR(PARITYERR), .rsp_err(rsp_err),
`endif
        .ahb(ahb.master)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic issue(input logic w, input logic [2*W-1:0] a, input logic [2*W-1:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        ahb.HREADYOUT = 1'b1; ahb.HRDATA = '0;
`ifdef GPIO_AHB_MASTER_PARITY_EN
        cfg_parity_odd = 1'b0; PARITYERR = 1'b0;
`endif
        tick(); tick();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
        HRESET = 1'b0;
        #1;
        checks++; if (ahb.HTRANS !== 2'b00 || ahb.HSEL !== 1'b0) begin errors++; $display("FAIL rst_htrans got %b/%b want 00/0", ahb.HTRANS, ahb.HSEL); end
        checks++; if (ahb.HADDR !== '0 || ahb.HWDATA !== '0 || ahb.HWRITE !== 1'b0) begin errors++; $display("FAIL rst_bus got %h/%h/%b want 0", ahb.HADDR, ahb.HWDATA, ahb.HWRITE); end
        checks++; if (rsp_valid !== 1'b0 || rsp_write !== 1'b0 || rsp_rdata !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rst_rsp got %b/%b/%h/%b want 0", rsp_valid, rsp_write, rsp_rdata, busy); end
        checks++; if (cmd_ready !== 1'b1 || ahb.HREADY !== 1'b1) begin errors++; $display("FAIL rst_ready got %b/%b want 1/1", cmd_ready, ahb.HREADY); end
    endtask

    task automatic test_single_write();
        issue(1'b1, 32'h0000_0004, 32'h0000_A5A5);
        tick();
        cmd_valid = 1'b0;
        checks++; if (ahb.HTRANS !== 2'b10 || ahb.HADDR !== 32'h4 || ahb.HWRITE !== 1'b1 || ahb.HSEL !== 1'b1) begin errors++; $display("FAIL wr_addr got %b/%h/%b/%b want 10/4/1/1", ahb.HTRANS, ahb.HADDR, ahb.HWRITE, ahb.HSEL); end
        tick();
        checks++; if (ahb.HWDATA !== 32'hA5A5 || ahb.HTRANS !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL wr_data got %h/%b/%b want a5a5/00/1", ahb.HWDATA, ahb.HTRANS, busy); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== '0 || busy !== 1'b0) begin errors++; $display("FAIL wr_rsp got %b/%b/%h/%b want 1/1/0/0", rsp_valid, rsp_write, rsp_rdata, busy); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || ahb.HADDR !== 32'h4 || ahb.HWRITE !== 1'b1) begin errors++; $display("FAIL wr_after got %b/%h/%b want 0/4/1", rsp_valid, ahb.HADDR, ahb.HWRITE); end
    endtask

    task automatic test_single_read();
        ahb.HRDATA = 32'h0000_1234;
        issue(1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
        tick();
        cmd_valid = 1'b0;
        checks++; if (ahb.HADDR !== 32'h0 || ahb.HWRITE !== 1'b0 || ahb.HTRANS !== 2'b10) begin errors++; $display("FAIL rd_addr got %h/%b/%b want 0/0/10", ahb.HADDR, ahb.HWRITE, ahb.HTRANS); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_early got %b want 0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h1234) begin errors++; $display("FAIL rd_rsp got %b/%b/%h want 1/0/1234", rsp_valid, rsp_write, rsp_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        ahb.HRDATA = 32'h0000_BEEF;
        issue(1'b1, 32'h0000_0008, 32'h0000_0055);
        tick();
        issue(1'b0, 32'h0000_000F, 32'h0);
        checks++; if (ahb.HADDR !== 32'h8 || ahb.HTRANS !== 2'b10) begin errors++; $display("FAIL b2b_wr_addr got %h/%b want 8/10", ahb.HADDR, ahb.HTRANS); end
        tick();
        cmd_valid = 1'b0;
        checks++; if (ahb.HADDR !== 32'hC || ahb.HWRITE !== 1'b0 || ahb.HTRANS !== 2'b10 || ahb.HWDATA !== 32'h55) begin errors++; $display("FAIL b2b_overlap got %h/%b/%b/%h want c/0/10/55", ahb.HADDR, ahb.HWRITE, ahb.HTRANS, ahb.HWDATA); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== '0) begin errors++; $display("FAIL b2b_rsp1 got %b/%b/%h want 1/1/0", rsp_valid, rsp_write, rsp_rdata); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'hBEEF) begin errors++; $display("FAIL b2b_rsp2 got %b/%b/%h want 1/0/beef", rsp_valid, rsp_write, rsp_rdata); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end got %b/%b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_wait_states();
        issue(1'b1, 32'h0000_0010, 32'h0000_0077);
        tick();
        cmd_valid = 1'b0;
        tick();
        ahb.HREADYOUT = 1'b0;
        issue(1'b0, 32'h0000_0020, 32'h0);
        #1;
        checks++; if (cmd_ready !== 1'b0 || ahb.HREADY !== 1'b0) begin errors++; $display("FAIL ws_ready got %b/%b want 0/0", cmd_ready, ahb.HREADY); end
        tick();
        checks++; if (ahb.HADDR !== 32'h10 || ahb.HWDATA !== 32'h77 || rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ws_hold got %h/%h/%b/%b want 10/77/0/1", ahb.HADDR, ahb.HWDATA, rsp_valid, busy); end
        tick();
        cmd_valid = 1'b0;
        ahb.HREADYOUT = 1'b1;
        checks++; if (rsp_valid !== 1'b0 || ahb.HWDATA !== 32'h77) begin errors++; $display("FAIL ws_hold2 got %b/%h want 0/77", rsp_valid, ahb.HWDATA); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1) begin errors++; $display("FAIL ws_rsp got %b/%b want 1/1", rsp_valid, rsp_write); end
        tick();
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 32'h0000_0030, 32'h0000_0099);
        tick();
        cmd_valid = 1'b0;
        tick();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        checks++; if (ahb.HTRANS !== 2'b00 || ahb.HSEL !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid got %b/%b/%b/%b want 00/0/0/0", ahb.HTRANS, ahb.HSEL, busy, rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || ahb.HWDATA !== '0) begin errors++; $display("FAIL rstmid_after got %b/%h want 0/0", rsp_valid, ahb.HWDATA); end
    endtask

`ifdef GPIO_AHB_MASTER_PARITY_EN
    task automatic test_parity();
        cfg_parity_odd = 1'b1;
        issue(1'b1, 32'h0000_0040, 32'h1);
        tick();
        cmd_valid = 1'b0;
        cfg_parity_odd = 1'b0;
        checks++; if (PARITYSEL !== 1'b1) begin errors++; $display("FAIL par_sel got %b want 1", PARITYSEL); end
        tick();
        PARITYERR = 1'b1;
        tick();
        PARITYERR = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL par_err got %b/%b want 1/1", rsp_valid, rsp_err); end
        tick();
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL par_clr got %b want 0", rsp_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_wait_states();
        test_reset_mid();
`ifdef GPIO_AHB_MASTER_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
